// File: rtl/radix4_divider_pkg.sv
// Shared definitions for the radix-4 arithmetic blocks (divider and Booth
// multiplier): the default operand width and the FSM state encoding.
// No ports; import with `import radix4_divider_pkg::*;`.
package radix4_divider_pkg;

    localparam int RADIX4_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/radix4_qsel.sv
// Radix-4 restoring quotient-digit select (combinational).
// Ports:
//   rs       shifted partial remainder {R, next two dividend bits}
//   d1/d2/d3 divisor multiples D, 2D, 3D (WIDTH+2 bits)
//   digit    selected quotient digit 0..3
//   rem_next rs - digit*D; always < D, so WIDTH bits are enough
module radix4_qsel #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH+1:0] rs,
    input  logic [WIDTH+1:0] d1,
    input  logic [WIDTH+1:0] d2,
    input  logic [WIDTH+1:0] d3,
    output logic [1:0]       digit,
    output logic [WIDTH-1:0] rem_next
);

    // Pick the largest multiple not exceeding rs. The subtraction is done
    // modulo 2^WIDTH: the true difference is below D, so truncation is exact.
    always_comb begin
        digit    = 2'd0;
        rem_next = rs[WIDTH-1:0];
        if (rs >= d3) begin
            digit    = 2'd3;
            rem_next = rs[WIDTH-1:0] - d3[WIDTH-1:0];
        end else if (rs >= d2) begin
            digit    = 2'd2;
            rem_next = rs[WIDTH-1:0] - d2[WIDTH-1:0];
        end else if (rs >= d1) begin
            digit    = 2'd1;
            rem_next = rs[WIDTH-1:0] - d1[WIDTH-1:0];
        end else begin
            digit    = 2'd0;
            rem_next = rs[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/radix4_divider.sv
// Sequential radix-4 restoring divider, two quotient bits per clock.
// Optional macro RADIX4_DIV_SIGNED_EN: two's-complement operands (absolute
// values divided, quotient/remainder signs fixed on the last RUN edge).
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           request, sampled only in IDLE
//   dividend/divisor operands captured on the accepted start
//   busy            high from accepted start through the done cycle
//   done            one-cycle pulse, results valid
//   quotient/remainder/div_by_zero  registered results, held until next DONE
module radix4_divider
    import radix4_divider_pkg::*;
#(
    parameter int WIDTH = RADIX4_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int RW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH / 2);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    state_t           state_r;
    logic [WIDTH-1:0] q_r;
    // Partial remainder is always below D, so its top two bits stay zero
    // and only WIDTH bits are stored.
    logic [WIDTH-1:0] r_r;
    logic [RW-1:0]    d1_r, d2_r, d3_r;
    logic [CW-1:0]    count_r;
    logic             dbz_r;

    logic [WIDTH-1:0] a_s, b_s;
    logic [RW-1:0]    d1_s, d2_s, d3_s;
    logic [RW-1:0]    rs_s;
    logic [1:0]       digit_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] q_next_s;
    logic [WIDTH-1:0] q_fin_s, r_fin_s;

`ifdef RADIX4_DIV_SIGNED_EN
    logic neg_q_r;
    logic neg_r_r;
`endif

    // Operand magnitudes and divisor multiples for the load.
    always_comb begin
`ifdef RADIX4_DIV_SIGNED_EN
        a_s = dividend[WIDTH-1] ? -dividend : dividend;
        b_s = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
        a_s = dividend;
        b_s = divisor;
`endif
        d1_s = {2'b00, b_s};
        d2_s = {1'b0, b_s, 1'b0};
        // 3D = D + 2D through the ripple adder; cannot overflow WIDTH+2 bits.
        d3_s = d1_s + d2_s;
    end

    // Shifted remainder, next quotient and sign-corrected final values.
    always_comb begin
        rs_s     = {r_r, q_r[WIDTH-1:WIDTH-2]};
        q_next_s = {q_r[WIDTH-3:0], digit_s};
`ifdef RADIX4_DIV_SIGNED_EN
        q_fin_s = neg_q_r ? -q_next_s : q_next_s;
        r_fin_s = neg_r_r ? -rem_next_s : rem_next_s;
`else
        q_fin_s = q_next_s;
        r_fin_s = rem_next_s;
`endif
    end

    radix4_qsel #(.WIDTH(WIDTH)) u_qsel (
        .rs       (rs_s),
        .d1       (d1_r),
        .d2       (d2_r),
        .d3       (d3_r),
        .digit    (digit_s),
        .rem_next (rem_next_s)
    );

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            q_r         <= {WIDTH{1'b0}};
            r_r         <= {WIDTH{1'b0}};
            d1_r        <= {RW{1'b0}};
            d2_r        <= {RW{1'b0}};
            d3_r        <= {RW{1'b0}};
            count_r     <= CNT_ZERO;
            dbz_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= {WIDTH{1'b0}};
            remainder   <= {WIDTH{1'b0}};
            div_by_zero <= 1'b0;
`ifdef RADIX4_DIV_SIGNED_EN
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy    <= 1'b1;
                        d1_r    <= d1_s;
                        d2_r    <= d2_s;
                        d3_r    <= d3_s;
                        count_r <= CNT_INIT;
`ifdef RADIX4_DIV_SIGNED_EN
                        neg_q_r <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_r_r <= dividend[WIDTH-1];
`endif
                        if (divisor == {WIDTH{1'b0}}) begin
                            // Skip RUN: results are fixed by definition.
                            q_r     <= {WIDTH{1'b1}};
                            r_r     <= dividend;
                            dbz_r   <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            q_r     <= a_s;
                            r_r     <= {WIDTH{1'b0}};
                            dbz_r   <= 1'b0;
                            state_r <= ST_RUN;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    count_r <= count_r - CNT_ONE;
                    if (count_r == CNT_ZERO) begin
                        q_r     <= q_fin_s;
                        r_r     <= r_fin_s;
                        state_r <= ST_DONE;
                    end else begin
                        q_r     <= q_next_s;
                        r_r     <= rem_next_s;
                    end
                end
                ST_DONE: begin
                    done        <= 1'b1;
                    quotient    <= q_r;
                    remainder   <= r_r;
                    div_by_zero <= dbz_r;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
